// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants and state encoding for the distance-transform passes
package dt_pkg;
    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;

    localparam logic [ADDR_W-1:0] BACK_START = 14'h3F7E;
    localparam logic [ADDR_W-1:0] BACK_END   = 14'h0081;

    // Neighbour offsets relative to the current pixel address
    localparam logic [ADDR_W-1:0] OFF_E    = 14'd1;
    localparam logic [ADDR_W-1:0] OFF_SW   = 14'd127;
    localparam logic [ADDR_W-1:0] OFF_S    = 14'd128;
    localparam logic [ADDR_W-1:0] OFF_SE   = 14'd129;
    localparam logic [ADDR_W-1:0] OFF_WRAP = 14'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_CUR,
        RD_E,
        RD_SW,
        RD_S,
        RD_SE,
        WRITE,
        DONE
    } state_t;
endpackage

// File: rtl/dt_min_plus1.sv
// rtl/dt_min_plus1.sv - min of four neighbours plus one (saturating), then min against current value
module dt_min_plus1
    import dt_pkg::*;
(
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] n0,
    input  logic [PIX_W-1:0] n1,
    input  logic [PIX_W-1:0] n2,
    input  logic [PIX_W-1:0] n3,
    output logic [PIX_W-1:0] result
);
    logic [PIX_W-1:0] m01;
    logic [PIX_W-1:0] m23;
    logic [PIX_W-1:0] m;
    logic [PIX_W:0]   p_wide;
    logic [PIX_W-1:0] p;

    always_comb begin
        m01    = (n0 < n1) ? n0 : n1;
        m23    = (n2 < n3) ? n2 : n3;
        m      = (m01 < m23) ? m01 : m23;
        p_wide = {1'b0, m} + {{PIX_W{1'b0}}, 1'b1};
        // 255 neighbours must stay 255 rather than wrapping to 0
        p      = p_wide[PIX_W] ? {PIX_W{1'b1}} : p_wide[PIX_W-1:0];
        result = (c <= p) ? c : p;
    end
endmodule

// File: rtl/backward_pass.sv
// rtl/backward_pass.sv - bottom-right to top-left chessboard distance pass over the result memory
module backward_pass
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              back_en,
    input  logic [PIX_W-1:0]  res_di,
    output logic [ADDR_W-1:0] res_addr_back,
    output logic [PIX_W-1:0]  res_do_back,
    output logic              res_wr_back,
    output logic              back_done
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [PIX_W-1:0]  c_q, c_d;
    logic [PIX_W-1:0]  e_q, e_d;
    logic [PIX_W-1:0]  sw_q, sw_d;
    logic [PIX_W-1:0]  s_q, s_d;
    logic [PIX_W-1:0]  se_q, se_d;

    logic [PIX_W-1:0]  result;
    logic [ADDR_W-1:0] cur_step;
    state_t            pix_state;
    logic [ADDR_W-1:0] pix_cur;

    dt_min_plus1 u_min (
        .c      (c_q),
        .n0     (e_q),
        .n1     (sw_q),
        .n2     (s_q),
        .n3     (se_q),
        .result (result)
    );

    // Where the scan goes once the current pixel is finished; folded into its last cycle
    always_comb begin
        cur_step = (cur_q[6:0] == 7'd1) ? (cur_q - OFF_WRAP) : (cur_q - OFF_E);
        if (cur_q == BACK_END) begin
            pix_state = DONE;
            pix_cur   = cur_q;
        end else begin
            pix_state = RD_CUR;
            pix_cur   = cur_step;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        c_d           = c_q;
        e_d           = e_q;
        sw_d          = sw_q;
        s_d           = s_q;
        se_d          = se_q;
        res_addr_back = '0;
        res_do_back   = '0;
        res_wr_back   = 1'b0;
        back_done     = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (back_en) begin
                    state_d = RD_CUR;
                end
            end
            RD_CUR: begin
                res_addr_back = cur_q;
                if (back_en) begin
                    c_d = res_di;
                    if (res_di == '0) begin
                        state_d = pix_state;
                        cur_d   = pix_cur;
                    end else begin
                        state_d = RD_E;
                    end
                end
            end
            RD_E: begin
                res_addr_back = cur_q + OFF_E;
                if (back_en) begin
                    e_d     = res_di;
                    state_d = RD_SW;
                end
            end
            RD_SW: begin
                res_addr_back = cur_q + OFF_SW;
                if (back_en) begin
                    sw_d    = res_di;
                    state_d = RD_S;
                end
            end
            RD_S: begin
                res_addr_back = cur_q + OFF_S;
                if (back_en) begin
                    s_d     = res_di;
                    state_d = RD_SE;
                end
            end
            RD_SE: begin
                res_addr_back = cur_q + OFF_SE;
                if (back_en) begin
                    se_d    = res_di;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                res_addr_back = cur_q;
                res_do_back   = result;
                res_wr_back   = back_en;
                if (back_en) begin
                    state_d = pix_state;
                    cur_d   = pix_cur;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= BACK_START;
            c_q     <= '0;
            e_q     <= '1;
            sw_q    <= '1;
            s_q     <= '1;
            se_q    <= '1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            c_q     <= c_d;
            e_q     <= e_d;
            sw_q    <= sw_d;
            s_q     <= s_d;
            se_q    <= se_d;
        end
    end
endmodule

// File: tb/tb_backward_pass.sv
// tb/tb_backward_pass.sv - self-checking bench for backward_pass against a software distance pass
module tb_backward_pass;
    import dt_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        back_en;
    logic [7:0]  res_di;
    logic [13:0] res_addr_back;
    logic [7:0]  res_do_back;
    logic        res_wr_back;
    logic        back_done;

    logic [7:0]  mem     [0:16383];
    logic [7:0]  ref_mem [0:16383];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign res_di = mem[res_addr_back];

    backward_pass dut (
        .clk           (clk),
        .reset         (reset),
        .back_en       (back_en),
        .res_di        (res_di),
        .res_addr_back (res_addr_back),
        .res_do_back   (res_do_back),
        .res_wr_back   (res_wr_back),
        .back_done     (back_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
    endtask

    function automatic int sat_inc(input int m);
        return (m + 1 > 255) ? 255 : m + 1;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Forward pass (W, NW, N, NE) used only to build realistic preloaded images
    task automatic forward_pass_mem();
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                int a, m;
                a = r * 128 + c;
                if (mem[a] != 0) begin
                    m = min2(min2(mem[a-1], mem[a-129]), min2(mem[a-128], mem[a-127]));
                    mem[a] = 8'(min2(mem[a], sat_inc(m)));
                end
            end
        end
    endtask

    // Reference: snapshot memory, count interior objects, apply the backward rule in scan order
    task automatic build_reference(output int objs);
        objs = 0;
        for (int a = 0; a < 16384; a++) ref_mem[a] = mem[a];
        for (int r = 126; r >= 1; r--) begin
            for (int c = 126; c >= 1; c--) begin
                int a, v, m;
                a = r * 128 + c;
                v = ref_mem[a];
                if (v != 0) begin
                    objs++;
                    m = min2(min2(ref_mem[a+1], ref_mem[a+127]), min2(ref_mem[a+128], ref_mem[a+129]));
                    ref_mem[a] = 8'(min2(v, sat_inc(m)));
                end
            end
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 16384; a++) if (mem[a] !== ref_mem[a]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic do_reset();
        back_en = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_scan(input int budget, input bit do_stall, input logic [13:0] anchor,
                            input bit chk_lat, output int cycles, output int writes);
        logic [13:0] prev_addr, a;
        bit stalled, finished;
        int rd_cyc;
        cycles = 0; writes = 0; stalled = 0; finished = 0; prev_addr = '0; rd_cyc = -100;
        back_en = 1'b1;
        while (!finished && cycles < budget) begin
            @(negedge clk);
            cycles++;
            a = res_addr_back;
            if (back_done) begin
                finished = 1;
            end else begin
                if (res_wr_back) begin
                    if (chk_lat && a == 14'd8256) check("single_write_latency", cycles - rd_cyc, 5);
                    mem[a] = res_do_back;
                    writes++;
                end else if (a == 14'd8256) begin
                    rd_cyc = cycles;
                end
                if (do_stall && !stalled && a == anchor + 14'd127 && prev_addr == anchor + 14'd1) begin
                    stalled = 1;
                    back_en = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        check("stall_addr_held", res_addr_back, anchor + 14'd127);
                        check("stall_no_write", res_wr_back, 0);
                    end
                    back_en = 1'b1;
                end
                prev_addr = a;
            end
        end
        check("scan_finished", finished, 1);
        if (do_stall) check("stall_reached", stalled, 1);
    endtask

    task automatic check_done_hold(input string tag);
        back_en = 1'b0;
        repeat (3) @(negedge clk);
        back_en = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_done_sticky"}, back_done, 1);
        check({tag, "_done_addr"}, res_addr_back, 0);
        check({tag, "_done_wr"}, res_wr_back, 0);
    endtask

    initial begin
        int objs, cyc, wr, found;
        reset   = 1'b1;
        back_en = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_addr", res_addr_back, 0);
        check("rst_do", res_do_back, 0);
        check("rst_wr", res_wr_back, 0);
        check("rst_done", back_done, 0);

        // All-background image: only RD_CUR cycles, no writes
        build_reference(objs);
        run_scan(20000, 0, '0, 0, cyc, wr);
        check("zero_writes", wr, 0);
        check("zero_cycles", cyc, 15877);
        compare_mem("zero_mem");
        check_done_hold("zero");

        // Directed image: 5x5 block, lone pixel, corner saturation
        do_reset();
        clear_mem();
        for (int r = 10; r <= 14; r++)
            for (int c = 10; c <= 14; c++) mem[r*128+c] = 8'd255;
        forward_pass_mem();
        check("fwd_preload_1676", mem[1676], 3);
        mem[8256]    = 8'd1;
        mem[14'h3F7E] = 8'd255;
        mem[14'h3F7F] = 8'd255;
        mem[14'h3FFD] = 8'd255;
        mem[14'h3FFE] = 8'd255;
        mem[14'h3FFF] = 8'd255;
        build_reference(objs);
        run_scan(30000, 0, '0, 1, cyc, wr);
        check("dir_writes", wr, objs);
        check("dir_cycles", cyc, 1 + 15876 + 5 * objs);
        check("single_8256", mem[8256], 1);
        check("blk_1548", mem[1548], 3);
        check("blk_1676", mem[1676], 2);
        check("blk_1804", mem[1804], 1);
        check("blk_1292", mem[1292], 1);
        check("sat_3F7E", mem[14'h3F7E], 255);
        compare_mem("dir_mem");
        check_done_hold("dir");

        // Random sparse image with a stall in RD_SW on a known object pixel
        do_reset();
        clear_mem();
        for (int i = 0; i < 250; i++)
            mem[$urandom_range(120, 2) * 128 + $urandom_range(126, 1)] = 8'($urandom_range(255, 1));
        mem[15420] = 8'($urandom_range(255, 1));
        mem[14'h3F7E] = 8'd9;
        mem[14'h3F7F] = 8'd200;
        mem[14'h3FFD] = 8'd200;
        mem[14'h3FFE] = 8'd3;
        mem[14'h3FFF] = 8'd200;
        build_reference(objs);
        run_scan(40000, 1, 14'd15420, 0, cyc, wr);
        check("rnd_writes", wr, objs);
        check("rnd_cycles", cyc, 1 + 15876 + 5 * objs);
        check("s3_result", mem[14'h3F7E], 4);
        compare_mem("rnd_mem");

        // Asynchronous reset in the middle of a scan
        do_reset();
        clear_mem();
        back_en = 1'b1;
        found = 0;
        for (int k = 0; k < 20000 && found == 0; k++) begin
            @(negedge clk);
            if (res_addr_back == 14'h2001) found = 1;
        end
        check("mid_scan_reached", found, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_addr", res_addr_back, 0);
        check("async_rst_do", res_do_back, 0);
        check("async_rst_wr", res_wr_back, 0);
        check("async_rst_done", back_done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("restart_idle_addr", res_addr_back, 0);
        @(negedge clk);
        check("restart_addr", res_addr_back, 14'h3F7E);
        check("restart_done", back_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
